// File: rtl/mips_if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_if_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } if_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_skid.sv
// One-entry hold register that catches a fetched word while decode is stalled.
module if_skid
    import mips_if_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_pop,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output logic         o_valid,
    output fetch_entry_t o_entry
);

    logic         r_valid;
    fetch_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, IF/ID register.
module if_stage
    import mips_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o
);

    if_state_t    r_state;
    if_state_t    w_nextState;
    logic [31:0]  r_pc;
    fetch_entry_t r_id;
    logic         r_idValid;
    logic [31:0]  r_idPc4;

    logic         w_gnt;
    logic         w_deliver;
    logic         w_holdValid;
    fetch_entry_t w_holdEntry;
    fetch_entry_t w_respEntry;
    logic         w_holdLoad;
    logic         w_holdPop;

    assign imem_req  = !rst && (r_state == S_REQ) && !w_holdValid;
    assign imem_addr = r_pc;
    assign w_gnt     = imem_req && imem_gnt;
    assign w_deliver = (r_state == S_WAIT) && imem_rvalid && !redirect_i;

    // pc already advanced on grant, so the returning word belongs to pc-4
    assign w_respEntry = '{instr: imem_rdata, pc: r_pc - 32'd4};

    assign w_holdLoad = w_deliver && stall_i && r_idValid;
    assign w_holdPop  = !redirect_i && !stall_i && w_holdValid;

    if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_holdLoad),
        .i_pop   (w_holdPop),
        .i_clear (redirect_i),
        .i_entry (w_respEntry),
        .o_valid (w_holdValid),
        .o_entry (w_holdEntry)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_REQ:  if (w_gnt) w_nextState = redirect_i ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)     w_nextState = S_REQ;
                else if (redirect_i) w_nextState = S_DROP;
            end
            S_DROP: if (imem_rvalid) w_nextState = S_REQ;
            default: w_nextState = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_nextState;
            if (redirect_i)  r_pc <= align_pc(redirect_pc_i);
            else if (w_gnt)  r_pc <= r_pc + 32'd4;
        end
    end

    // A held word always drains before a new one can arrive, since hold blocks requests
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id      <= '0;
            r_idValid <= 1'b0;
            r_idPc4   <= '0;
        end else if (redirect_i) begin
            r_idValid <= 1'b0;
            r_id.instr <= NOP_INSTR;
        end else if (!stall_i && w_holdValid) begin
            r_id      <= w_holdEntry;
            r_idValid <= 1'b1;
            r_idPc4   <= w_holdEntry.pc + 32'd4;
        end else if (w_deliver && (!stall_i || !r_idValid)) begin
            r_id      <= w_respEntry;
            r_idValid <= 1'b1;
            r_idPc4   <= w_respEntry.pc + 32'd4;
        end else if (!stall_i) begin
            r_idValid <= 1'b0;
            r_id.instr <= NOP_INSTR;
        end
    end

    assign id_valid_o = r_idValid;
    assign id_instr_o = r_id.instr;
    assign id_pc_o    = r_id.pc;
    assign id_pc4_o   = r_idPc4;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC and issues word fetches to instruction memory over a request/grant/response handshake. Presents the fetched word to the decode stage through the IF/ID register; the control unit decodes that word. Handles hazard-unit stalls with a one-entry skid buffer and branch/jump redirects by squashing wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  response word valid; at least 1 cycle after gnt; in order
- imem_rdata  in  32  response word
- stall_i  in  1  hazard unit: hold IF/ID contents
- redirect_i  in  1  taken branch/jump from EX: refetch from redirect_pc_i
- redirect_pc_i  in  32  redirect target
- id_valid_o  out  1  IF/ID holds a real instruction
- id_instr_o  out  32  instruction to decode; 32'h0 (sll nop) when invalid
- id_pc_o  out  32  PC of id_instr_o
- id_pc4_o  out  32  id_pc_o + 4

## Operation
- At most one request outstanding. FSM states:
  - S_REQ: imem_req=1 unless hold_valid. On gnt, pc<=pc+4 and go to S_WAIT.
  - S_WAIT: wait for rvalid. On rvalid, deliver the word and go to S_REQ.
  - S_DROP: wait for rvalid. On rvalid, discard the word and go to S_REQ.
- imem_addr = pc at all times; pc[1:0] is always 0.
- Delivery of a word W with its PC:
  - If id_valid_o=0 or stall_i=0, W loads into IF/ID.
  - Otherwise W goes to the hold register (hold_valid<=1).
- IF/ID update when stall_i=0:
  - If hold_valid, the hold entry moves into IF/ID and hold_valid<=0.
  - Else if a word is delivered this cycle, it loads into IF/ID.
  - Else IF/ID becomes a bubble: id_valid_o=0, id_instr_o=0.
- stall_i=1: IF/ID is unchanged. Fetching continues until the hold register is full.
- Redirect (redirect_i=1) has priority over stall and delivery:
  - pc <= {redirect_pc_i[31:2],2'b00}.
  - IF/ID becomes a bubble; hold_valid<=0.
  - S_WAIT, or S_REQ with gnt in the same cycle: go to S_DROP.
  - S_WAIT with rvalid in the same cycle: discard the word and go to S_REQ.
  - S_REQ without gnt: stay in S_REQ. The request is withdrawn and re-presented next cycle at the new pc.
  - S_DROP: stay in S_DROP.
- Arithmetic is modulo 2^32; pc 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - state=S_REQ, pc=RESET_PC, hold_valid=0.
  - id_valid_o=0, id_instr_o=0, id_pc_o=0, id_pc4_o=0.
  - imem_req=0 while rst=1.
- Cycle after rst falls: imem_req=1, imem_addr=RESET_PC.
- Best-case latency: gnt in cycle 0, rvalid in cycle 1, id_valid_o=1 in cycle 2.
- Best-case throughput is one instruction per 2 cycles, with no back-to-back requests.
- Redirect in cycle N: IF/ID is a bubble in N+1. The first target request is visible in N+1, or after the dropped response arrives.
- rst asserted mid-operation: everything returns to reset values next edge. Any in-flight response is ignored; rvalid is not accepted during or in the cycle after reset.

## Structure
- Package mips_if_pkg:
  - state enum {S_REQ, S_WAIT, S_DROP}
  - RESET_PC_DEFAULT
  - NOP_INSTR=32'h0
  - a struct {instr, pc} shared by hold and IF/ID
- Sub-module if_skid: one-entry hold register with load/pop/clear and hold_valid.
- The top holds the FSM, pc, and IF/ID register.

## Test plan
- Reset with gnt tied 1 and rvalid one cycle after gnt. Memory holds 0x2008_0005 at 0x3000 and 0x2009_0007 at 0x3004. Required: id_instr_o=0x20080005, id_pc_o=0x3000, id_pc4_o=0x3004 in cycle 2; next instruction in cycle 4; bubbles (id_instr_o=0) in between.
- gnt delayed 3 cycles and rvalid delayed 2 cycles. Required: imem_addr held at 0x3000 with req=1 until gnt; no second request before rvalid.
- stall_i=1 with IF/ID valid while a response arrives. Required: IF/ID unchanged, hold filled, req=0. Release stall: the held word appears the next cycle with the correct PC.
- redirect_i=1 to 0x3040 while in S_WAIT. Required: the returning word is discarded, the next request is at 0x3040, and id_valid_o=0 until the 0x3040 word arrives.
- Two corner cases in one run:
  - redirect_i to 0x3043 coinciding with rvalid: word discarded, next fetch at 0x3040.
  - redirect_i coinciding with stall_i: redirect wins and IF/ID becomes a bubble.
- rst asserted while in S_WAIT with hold full. Required: all reset values next cycle; a stale rvalid during reset is ignored; a fresh fetch at 0x3000 follows.
